handshake_rr_merge: RTL
=======================

Name: handshake_rr_merge

Overview:
- Round-robin merger for the req/ack handshake used by async_operator graphs.
- Lets NUM_SRC producer-style sources (producer modules or out operators) share one consumer-side port, e.g. a single arf din port.
- Upstream, it acts as a consumer: it issues req to one source at a time and captures data on the ack pulse.
- Downstream, it acts as a producer: it answers dn_req with a one-cycle ack, data and a source tag. A per-source timeout skips stalled sources.

Parameters:
- num_src, 4, number of upstream sources (2..16)
- data_width, 32, payload width
- src_w, 2, width of the source tag; must be at least clog2(num_src)
- timeout, 16, cycles to wait for up_ack before skipping the source; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- en_mask  in  num_src  per-source enable; sampled only in SELECT
- up_req  out  num_src  request to source i; at most one bit set
- up_ack  in  num_src  one-cycle ack pulse from source i
- up_data  in  num_src*data_width  source i data in slice [data_width*(i+1)-1 : data_width*i]
- dn_req  in  1  downstream request (level)
- dn_ack  out  1  one-cycle ack to downstream
- dn_data  out  data_width  delivered payload; held until the next delivery
- dn_src  out  src_w  index of the source that produced dn_data
- timeout_evt  out  1  one-cycle pulse when a source is skipped
- late_ack  out  1  one-cycle pulse when an up_ack arrives outside a matching FETCH

Behaviour:
- Reset (rst=0 at a clk edge): up_req=0, dn_ack=0, dn_data=0, dn_src=0, timeout_evt=0, late_ack=0, ptr=0, grant=0, tcnt=0, buf=0, state=SELECT.
- Reset mid-transfer aborts it: captured data is discarded and any pending req is dropped.
- State SELECT (buffer empty):
  - grant = first i with en_mask[i]=1, scanning ptr, ptr+1, ..., wrapping modulo num_src.
  - If none is enabled, stay in SELECT.
  - Otherwise: up_req[grant]<=1, tcnt<=0, go to FETCH.
  - SELECT costs 1 cycle.
- State FETCH:
  - If up_ack[grant]: buf<=up_data slice of grant, up_req<=0, go to FULL. Ack takes priority over timeout in the same cycle.
  - Else if timeout!=0 and tcnt==timeout-1: up_req<=0, timeout_evt<=1, ptr<=grant+1 (wrap), go to SELECT.
  - Else tcnt<=tcnt+1.
- State FULL:
  - When dn_req & ~dn_ack: dn_ack<=1, dn_data<=buf, dn_src<=grant, ptr<=grant+1 (wrap), go to SELECT.
  - dn_ack is high for exactly one cycle. It never asserts on consecutive cycles, matching the producer rule req & ~ack.
- late_ack: any up_ack[i] seen when not (state==FETCH and i==grant). Its data is dropped; up_ack on a non-granted index during FETCH also pulses late_ack. A late ack does not change state.
- Latency with a zero-wait source and dn_req held high:
  - SELECT (1 cycle), then FETCH; the source acks 1 cycle after seeing req (≥2 cycles).
  - FULL gives dn_ack on the next edge.
  - Throughput: one item per ≥4 cycles.
- Fairness: after a source is served or skipped, it has the lowest priority in the next SELECT.
- en_mask changes during FETCH/FULL do not abort the current transfer.
- Wrap: ptr==num_src-1 advances to 0.
- tcnt is wide enough for timeout-1; it is not used when timeout=0.

Decomposition:
- Shared package: state encoding (SELECT=0, FETCH=1, FULL=2), and a clog2 function for default tag and tcnt widths.
- One natural sub-module: rr_pick (combinational). Inputs: mask, ptr. Outputs: grant index and a valid flag. It is reusable by other schedulers.
- FSM, timeout counter and buffer stay in handshake_rr_merge.

Test Plan:
- Reset: hold rst=0 for 3 cycles with up_ack pulsing → all outputs 0, no late_ack, state SELECT.
- Fairness: num_src=4, all enabled, each source a producer with initial_value i*100, consumer with fail_rate 0, 12 items.
  - Required dn_src order: 0,1,2,3,0,1,2,3,0,1,2,3.
  - Required dn_data: 0,100,200,300,1,101,...
- Mask: en_mask=4'b1010.
  - Required: only sources 1,3 receive up_req; dn_src alternates 1,3.
  - Then set en_mask=0 in FULL → the current item is still delivered, then no up_req is issued.
- Timeout: timeout=16, source 2 never acks.
  - Required: up_req[2] high exactly 16 cycles, timeout_evt one pulse, next grant=3, order 0,1,3,0,1,3.
- Ack/timeout collision: source acks in the cycle tcnt==15 → data delivered, no timeout_evt.
  - An ack injected 1 cycle after a timeout → late_ack pulse, data not delivered.
- Backpressure: consumer fail_rate=70, 5000 items.
  - Required: dn_ack never high on two consecutive cycles, no data loss or duplication per source, each source's sequence strictly +1.

Source files
------------

// File: rtl/handshake_rr_merge_pkg.sv
// Shared definitions for the round-robin req/ack merger: FSM encoding and a
// width helper used to size the source tag and the timeout counter.
package handshake_rr_merge_pkg;

    localparam logic [1:0] ST_SELECT = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    // Ceiling log2, returning at least 1 so it can size a vector directly.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits++;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/handshake_rr_merge_rr_pick.sv
// Combinational round-robin picker: first set bit of mask scanning from ptr
// upward with wrap. Reusable by any scheduler that keeps its own pointer.
module rr_pick #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] mask,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   grant,
    output logic               valid
);

    int idx;

    // Scanning from the far end lets the closest candidate to ptr win last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            if (mask[idx]) begin
                grant = SRC_W'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_rr_merge.sv
// Round-robin merger: fetches one item at a time from NUM_SRC req/ack sources
// and hands it to a single downstream consumer with a source tag.
module handshake_rr_merge
    import handshake_rr_merge_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int SRC_W   = clog2(NUM_SRC),
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        en_mask,
    output logic [NUM_SRC-1:0]        up_req,
    input  logic [NUM_SRC-1:0]        up_ack,
    input  logic [NUM_SRC*DATA_W-1:0] up_data,
    input  logic                      dn_req,
    output logic                      dn_ack,
    output logic [DATA_W-1:0]         dn_data,
    output logic [SRC_W-1:0]          dn_src,
    output logic                      timeout_evt,
    output logic                      late_ack
);

    localparam int TCNT_W = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]         state;
    logic [SRC_W-1:0]   ptr;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   pick;
    logic               pick_vld;
    logic [TCNT_W-1:0]  tcnt;
    logic [DATA_W-1:0]  data_buf;
    logic [DATA_W-1:0]  sel_data;
    logic [NUM_SRC-1:0] expect_ack;

    function automatic logic [SRC_W-1:0] wrap_next(input logic [SRC_W-1:0] idx);
        return (int'(idx) == NUM_SRC - 1) ? '0 : idx + SRC_W'(1);
    endfunction

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .mask  (en_mask),
        .ptr   (ptr),
        .grant (pick),
        .valid (pick_vld)
    );

    // Only the granted source's ack is meaningful, and only while fetching.
    always_comb begin
        expect_ack = '0;
        if (state == ST_FETCH) begin
            expect_ack[grant] = 1'b1;
        end
    end

    always_comb begin
        sel_data = up_data[int'(grant)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_SELECT;
            ptr         <= '0;
            grant       <= '0;
            tcnt        <= '0;
            data_buf    <= '0;
            up_req      <= '0;
            dn_ack      <= 1'b0;
            dn_data     <= '0;
            dn_src      <= '0;
            timeout_evt <= 1'b0;
            late_ack    <= 1'b0;
        end else begin
            dn_ack      <= 1'b0;
            timeout_evt <= 1'b0;
            late_ack    <= |(up_ack & ~expect_ack);
            case (state)
                ST_SELECT: begin
                    if (pick_vld) begin
                        grant  <= pick;
                        up_req <= NUM_SRC'(1) << pick;
                        tcnt   <= '0;
                        state  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // An ack landing on the last timeout cycle still counts.
                    if (up_ack[grant]) begin
                        data_buf <= sel_data;
                        up_req   <= '0;
                        state    <= ST_FULL;
                    end else if (TIMEOUT != 0 && tcnt == TCNT_LAST) begin
                        up_req      <= '0;
                        timeout_evt <= 1'b1;
                        ptr         <= wrap_next(grant);
                        state       <= ST_SELECT;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                ST_FULL: begin
                    if (dn_req && !dn_ack) begin
                        dn_ack  <= 1'b1;
                        dn_data <= data_buf;
                        dn_src  <= grant;
                        ptr     <= wrap_next(grant);
                        state   <= ST_SELECT;
                    end
                end
                default: begin
                    state <= ST_SELECT;
                end
            endcase
        end
    end

endmodule
